// File: rtl/caxi4interconnect_dependency_check_if.sv
// Address-request bundle between upstream master port, transaction controller and target mux.
// slave modport is the dependency-check gate; master modport is its environment.
interface caxi4interconnect_dependency_check_if #(
  parameter int NUM_SLAVES_WIDTH = 2,
  parameter int MASTERID_WIDTH   = 4,
  parameter int OPEN_TRANS_WIDTH = 2,
  parameter int PAYLOAD_WIDTH    = 32
);
  logic                        srcValid;
  logic                        srcReady;
  logic [MASTERID_WIDTH-1:0]   srcID;
  logic [NUM_SLAVES_WIDTH-1:0] srcSlaveID;
  logic [PAYLOAD_WIDTH-1:0]    srcPayload;

  logic [MASTERID_WIDTH-1:0]   currTransID;
  logic [NUM_SLAVES_WIDTH-1:0] currTransSlaveID;
  logic                        threadAvail;
  logic                        threadValid;
  logic [OPEN_TRANS_WIDTH-1:0] threadCount;
  logic [NUM_SLAVES_WIDTH-1:0] threadSlaveID;
  logic                        openTransInc;
  logic                        depStall;

  logic                        reqValid;
  logic                        reqReady;
  logic [MASTERID_WIDTH-1:0]   reqID;
  logic [NUM_SLAVES_WIDTH-1:0] reqSlaveID;
  logic [PAYLOAD_WIDTH-1:0]    reqPayload;

  modport master (
    output srcValid, srcID, srcSlaveID, srcPayload,
    input  srcReady,
    input  currTransID, currTransSlaveID, openTransInc, depStall,
    output threadAvail, threadValid, threadCount, threadSlaveID,
    input  reqValid, reqID, reqSlaveID, reqPayload,
    output reqReady
  );

  modport slave (
    input  srcValid, srcID, srcSlaveID, srcPayload,
    output srcReady,
    output currTransID, currTransSlaveID, openTransInc, depStall,
    input  threadAvail, threadValid, threadCount, threadSlaveID,
    output reqValid, reqID, reqSlaveID, reqPayload,
    input  reqReady
  );
endinterface

// File: rtl/caxi4interconnect_dependency_check.sv
// Per-master address gate: holds a request until same-ID AXI ordering allows issue.
// Accept -> check -> issue; 2 cycles accept-to-reqValid, 1 request per 3 cycles at best.
module caxi4interconnect_dependency_check #(
  parameter int NUM_SLAVES_WIDTH = 2,
  parameter int MASTERID_WIDTH   = 4,
  parameter int OPEN_TRANS_MAX   = 3,
  parameter int OPEN_TRANS_WIDTH = 2,
  parameter int PAYLOAD_WIDTH    = 32
) (
  input logic sysClk,
  input logic sysReset,
  caxi4interconnect_dependency_check_if.slave bus
);

  localparam logic [OPEN_TRANS_WIDTH-1:0] LP_OPEN_MAX = OPEN_TRANS_WIDTH'(OPEN_TRANS_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t                      r_state;
  logic                        r_src_ready;
  logic                        r_req_valid;
  logic [MASTERID_WIDTH-1:0]   r_curr_id;
  logic [NUM_SLAVES_WIDTH-1:0] r_curr_slave;
  logic [PAYLOAD_WIDTH-1:0]    r_payload;

  logic w_allow;
  logic w_stall;

  // A live thread may take another request only to the same slave and below the
  // outstanding limit; with no live thread a free slot is required.
  assign w_allow = (bus.threadValid && (bus.threadSlaveID == r_curr_slave) &&
                    (bus.threadCount < LP_OPEN_MAX)) ||
                   (!bus.threadValid && bus.threadAvail);
  assign w_stall = (r_state == ST_CHECK) && !w_allow;

  always_ff @(posedge sysClk or negedge sysReset) begin
    if (!sysReset) begin
      r_state      <= ST_IDLE;
      r_src_ready  <= 1'b1;
      r_req_valid  <= 1'b0;
      r_curr_id    <= '0;
      r_curr_slave <= '0;
      r_payload    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.srcValid && r_src_ready) begin
            r_curr_id    <= bus.srcID;
            r_curr_slave <= bus.srcSlaveID;
            r_payload    <= bus.srcPayload;
            r_src_ready  <= 1'b0;
            r_state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_allow) begin
            r_req_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // No re-check here: only this gate increments the thread, decrements only relax it.
          if (bus.reqReady) begin
            r_req_valid <= 1'b0;
            r_src_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_req_valid <= 1'b0;
          r_src_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.srcReady         = r_src_ready;
  assign bus.currTransID      = r_curr_id;
  assign bus.currTransSlaveID = r_curr_slave;
  assign bus.reqValid         = r_req_valid;
  assign bus.reqID            = r_curr_id;
  assign bus.reqSlaveID       = r_curr_slave;
  assign bus.reqPayload       = r_payload;
  assign bus.openTransInc     = r_req_valid && bus.reqReady;
  assign bus.depStall         = w_stall;

endmodule

// File: tb/tb_caxi4interconnect_dependency_check.sv
// Bench for the dependency-check gate: directed scenarios plus random traffic,
// checked by a cycle monitor and a request scoreboard.
module tb_caxi4interconnect_dependency_check;
  localparam int NSW = 2;
  localparam int MW  = 4;
  localparam int OTM = 3;
  localparam int OTW = 2;
  localparam int PW  = 32;

  logic sysClk   = 1'b0;
  logic sysReset = 1'b0;
  always #5 sysClk = ~sysClk;

  caxi4interconnect_dependency_check_if #(
    .NUM_SLAVES_WIDTH(NSW), .MASTERID_WIDTH(MW), .OPEN_TRANS_WIDTH(OTW), .PAYLOAD_WIDTH(PW)
  ) bus ();

  caxi4interconnect_dependency_check #(
    .NUM_SLAVES_WIDTH(NSW), .MASTERID_WIDTH(MW), .OPEN_TRANS_MAX(OTM),
    .OPEN_TRANS_WIDTH(OTW), .PAYLOAD_WIDTH(PW)
  ) dut (
    .sysClk  (sysClk),
    .sysReset(sysReset),
    .bus     (bus)
  );

  typedef struct packed {
    logic [MW-1:0]  id;
    logic [NSW-1:0] sl;
    logic [PW-1:0]  pl;
  } req_t;

  typedef enum {P_IDLE, P_CHECK, P_ISSUE} ph_t;

  req_t sb_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   inc_pulses = 0;

  ph_t            ph = P_IDLE;
  logic [MW-1:0]  m_id;
  logic [NSW-1:0] m_sl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ordering rule stated directly: same-slave thread below the limit, or a free slot.
  function automatic bit rule_allow(bit tv, bit ta, int cnt, int tsl, int sl);
    if (tv) return (tsl == sl) && (cnt < OTM);
    return ta;
  endfunction

  // Monitor: per-cycle expectations from the phase model, scoreboard pop on handshake.
  always @(negedge sysClk) begin
    bit   allow;
    req_t e;
    if (!sysReset) begin
      chk("rst_srcReady", 64'(bus.srcReady), 64'(1));
      chk("rst_reqValid", 64'(bus.reqValid), 64'(0));
      chk("rst_openTransInc", 64'(bus.openTransInc), 64'(0));
      chk("rst_depStall", 64'(bus.depStall), 64'(0));
      chk("rst_currTransID", 64'(bus.currTransID), 64'(0));
      chk("rst_currTransSlaveID", 64'(bus.currTransSlaveID), 64'(0));
      chk("rst_reqPayload", 64'(bus.reqPayload), 64'(0));
      ph = P_IDLE;
    end else begin
      allow = rule_allow(bus.threadValid, bus.threadAvail, int'(bus.threadCount),
                         int'(bus.threadSlaveID), int'(m_sl));
      if (bus.openTransInc) inc_pulses++;
      chk("srcReady", 64'(bus.srcReady), 64'(ph == P_IDLE));
      chk("reqValid", 64'(bus.reqValid), 64'(ph == P_ISSUE));
      chk("depStall", 64'(bus.depStall), 64'(ph == P_CHECK && !allow));
      chk("openTransInc", 64'(bus.openTransInc), 64'(ph == P_ISSUE && bus.reqReady));
      if (ph != P_IDLE) begin
        chk("currTransID", 64'(bus.currTransID), 64'(m_id));
        chk("currTransSlaveID", 64'(bus.currTransSlaveID), 64'(m_sl));
      end
      if (ph == P_ISSUE && sb_q.size() > 0) begin
        chk("reqID", 64'(bus.reqID), 64'(sb_q[0].id));
        chk("reqSlaveID", 64'(bus.reqSlaveID), 64'(sb_q[0].sl));
        chk("reqPayload", 64'(bus.reqPayload), 64'(sb_q[0].pl));
      end
      case (ph)
        P_IDLE: if (bus.srcValid) begin
          m_id = bus.srcID;
          m_sl = bus.srcSlaveID;
          ph   = P_CHECK;
        end
        P_CHECK: if (allow) ph = P_ISSUE;
        P_ISSUE: if (bus.reqReady) begin
          if (sb_q.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
          else e = sb_q.pop_front();
          ph = P_IDLE;
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sysClk);
    #1;
  endtask

  task automatic set_thread(input bit tv, input bit ta, input logic [OTW-1:0] cnt,
                            input logic [NSW-1:0] tsl);
    bus.threadValid   = tv;
    bus.threadAvail   = ta;
    bus.threadCount   = cnt;
    bus.threadSlaveID = tsl;
  endtask

  // Present a request, record its expectation, hold until accepted (bounded).
  task automatic send(input logic [MW-1:0] id, input logic [NSW-1:0] sl, input logic [PW-1:0] pl);
    bit acc;
    bus.srcValid   = 1'b1;
    bus.srcID      = id;
    bus.srcSlaveID = sl;
    bus.srcPayload = pl;
    sb_q.push_back('{id: id, sl: sl, pl: pl});
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge sysClk);
      acc = bus.srcValid && bus.srcReady;
      tick(1);
    end
    if (!acc) chk("accept_timeout", 64'(0), 64'(1));
    bus.srcValid = 1'b0;
  endtask

  initial begin
    int   p0;
    bit   pending;
    bit   acc;
    req_t r;

    bus.srcValid = 1'b0; bus.srcID = '0; bus.srcSlaveID = '0; bus.srcPayload = '0;
    bus.reqReady = 1'b0;
    set_thread(1'b0, 1'b0, 2'd0, 2'd0);
    tick(3);
    sysReset = 1'b1;
    tick(2);

    // Free path: no matching thread, slot available, target ready.
    set_thread(1'b0, 1'b1, 2'd0, 2'd0);
    bus.reqReady = 1'b1;
    p0 = inc_pulses;
    send(4'h3, 2'd1, $urandom);
    chk("t1_reqValid_check_cycle", 64'(bus.reqValid), 64'(0));
    tick(1);
    chk("t1_reqValid_latency", 64'(bus.reqValid), 64'(1));
    tick(2);
    chk("t1_single_inc", 64'(inc_pulses - p0), 64'(1));
    chk("t1_back_idle", 64'(bus.srcReady), 64'(1));

    // Thread at its outstanding limit, then one completion frees it.
    set_thread(1'b1, 1'b1, 2'd3, 2'd1);
    p0 = inc_pulses;
    send(4'h3, 2'd1, $urandom);
    tick(4);
    chk("t2_stall", 64'(bus.depStall), 64'(1));
    chk("t2_no_req", 64'(bus.reqValid), 64'(0));
    bus.threadCount = 2'd2;
    tick(1);
    chk("t2_issue", 64'(bus.reqValid), 64'(1));
    tick(2);
    chk("t2_single_inc", 64'(inc_pulses - p0), 64'(1));

    // Same ID open to a different slave blocks until that thread drains.
    set_thread(1'b1, 1'b1, 2'd1, 2'd0);
    send(4'h5, 2'd2, $urandom);
    tick(3);
    chk("t3_stall", 64'(bus.depStall), 64'(1));
    set_thread(1'b0, 1'b1, 2'd0, 2'd0);
    tick(3);

    // No free slot: stall indefinitely until one appears.
    set_thread(1'b0, 1'b0, 2'd0, 2'd0);
    send(4'h7, 2'd0, 32'hDEADBEEF);
    tick(6);
    chk("t4_srcReady_low", 64'(bus.srcReady), 64'(0));
    chk("t4_stall", 64'(bus.depStall), 64'(1));
    bus.threadAvail = 1'b1;
    tick(3);

    // Target back-pressure holds the request without incrementing.
    bus.reqReady = 1'b0;
    p0 = inc_pulses;
    send(4'h9, 2'd3, $urandom);
    tick(6);
    chk("t5_no_inc_held", 64'(inc_pulses - p0), 64'(0));
    chk("t5_reqValid_held", 64'(bus.reqValid), 64'(1));
    bus.reqReady = 1'b1;
    tick(2);
    chk("t5_single_inc", 64'(inc_pulses - p0), 64'(1));

    // Reset while issuing drops the request with no increment.
    bus.reqReady = 1'b0;
    send(4'hA, 2'd1, $urandom);
    tick(1);
    chk("t6_in_issue", 64'(bus.reqValid), 64'(1));
    sysReset = 1'b0;
    #1;
    chk("t6_rst_srcReady", 64'(bus.srcReady), 64'(1));
    chk("t6_rst_reqValid", 64'(bus.reqValid), 64'(0));
    sb_q.delete();
    tick(2);
    sysReset = 1'b1;
    bus.reqReady = 1'b1;
    p0 = inc_pulses;
    tick(4);
    chk("t6_no_inc_after_rst", 64'(inc_pulses - p0), 64'(0));

    // Random traffic against the monitor/scoreboard.
    pending = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge sysClk);
      acc = bus.srcValid && bus.srcReady;
      tick(1);
      if (acc) begin
        pending = 1'b0;
        bus.srcValid = 1'b0;
      end
      set_thread(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 7),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      bus.reqReady = ($urandom_range(0, 9) < 6);
      if (!pending && $urandom_range(0, 2) != 0) begin
        r.id = 4'($urandom); r.sl = 2'($urandom); r.pl = $urandom;
        bus.srcValid   = 1'b1;
        bus.srcID      = r.id;
        bus.srcSlaveID = r.sl;
        bus.srcPayload = r.pl;
        sb_q.push_back(r);
        pending = 1'b1;
      end
    end

    // Drain with everything permissive.
    for (int c = 0; c < 20; c++) begin
      @(negedge sysClk);
      acc = bus.srcValid && bus.srcReady;
      tick(1);
      if (acc) bus.srcValid = 1'b0;
      set_thread(1'b0, 1'b1, 2'd0, 2'd0);
      bus.reqReady = 1'b1;
    end
    chk("final_srcValid_accepted", 64'(bus.srcValid), 64'(0));
    chk("final_sb_empty", 64'(sb_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
